// File: rtl/watch_mode_ctrl.sv
// Front-panel controller for the alarm watch.
// The block synchronises and debounces the four raw buttons. It then runs the
// top-level mode FSM (CLOCK / SET_TIME / SET_ALARM / STOPWATCH), the stopwatch
// handshake sub-FSM, and the field-select and increment logic used while setting
// the time or alarm. Every output comes straight from a register.
module watch_mode_ctrl #(
    parameter int DEBOUNCE_MS = 20,
    parameter int HOLD_MS     = 1000,
    parameter int REPEAT_MS   = 200,
    parameter int TIMEOUT_MS  = 30000
) (
    input  logic       Clock_1MSec,
    input  logic       Reset,
    input  logic       Btn_Mode,
    input  logic       Btn_Start,
    input  logic       Btn_Reset,
    input  logic       Btn_Set,
    output logic [1:0] Mode,
    output logic       Set_Field,
    output logic       Inc_P,
    output logic       Start_S,
    output logic       Stop_S,
    output logic       Reset_S,
    output logic       Control
);

    localparam int DBW = $clog2(DEBOUNCE_MS + 1);
    localparam int HW  = $clog2(HOLD_MS + 1);
    localparam int RW  = $clog2(REPEAT_MS + 1);
    localparam int TW  = $clog2(TIMEOUT_MS + 1);

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_MS - 1);
    localparam logic [DBW-1:0] DB_ONE    = DBW'(1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_MS - 1);
    localparam logic [HW-1:0]  HOLD_MAX  = HW'(HOLD_MS);
    localparam logic [HW-1:0]  HOLD_ONE  = HW'(1);
    localparam logic [RW-1:0]  REP_LAST  = RW'(REPEAT_MS - 1);
    localparam logic [RW-1:0]  REP_ONE   = RW'(1);
    localparam logic [TW-1:0]  IDLE_MAX  = TW'(TIMEOUT_MS);
    localparam logic [TW-1:0]  IDLE_ONE  = TW'(1);

    // Bit positions of the buttons inside the packed button vectors
    localparam int B_MODE  = 0;
    localparam int B_START = 1;
    localparam int B_RESET = 2;
    localparam int B_SET   = 3;

    typedef enum logic [1:0] {
        MODE_CLOCK     = 2'b00,
        MODE_SET_TIME  = 2'b01,
        MODE_SET_ALARM = 2'b10,
        MODE_STOPWATCH = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        SW_READY   = 2'b00,
        SW_RUNNING = 2'b01,
        SW_STOPPED = 2'b10
    } sw_t;

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic [3:0]     btn_raw_s;
    logic [3:0]     sync1_r;
    logic [3:0]     sync2_r;
    logic [3:0]     deb_r;
    logic [3:0]     deb_d_r;
    logic [3:0]     press_r;
    logic [DBW-1:0] db_cnt_r [4];

    assign btn_raw_s = {Btn_Set, Btn_Reset, Btn_Start, Btn_Mode};

    // Synchronise, debounce and turn each debounced rising edge into a one-cycle press
    always_ff @(posedge Clock_1MSec) begin
        if (Reset) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
            deb_r   <= 4'b0000;
            deb_d_r <= 4'b0000;
            press_r <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                db_cnt_r[i] <= '0;
            end
        end else begin
            sync1_r <= btn_raw_s;
            sync2_r <= sync1_r;
            deb_d_r <= deb_r;
            press_r <= deb_r & ~deb_d_r;
            for (int i = 0; i < 4; i++) begin
                // A sample matching the current level means a glitch, so the run restarts
                if (sync2_r[i] == deb_r[i]) begin
                    db_cnt_r[i] <= '0;
                end else if (db_cnt_r[i] == DB_LAST) begin
                    db_cnt_r[i] <= '0;
                    deb_r[i]    <= ~deb_r[i];
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Mode FSM, stopwatch sub-FSM, setting logic
    // ------------------------------------------------------------------
    mode_t         mode_r, mode_s;
    sw_t           sw_r, sw_s;
    logic          field_r, field_s;
    logic          inc_pulse_r, inc_pulse_s;
    logic          stop_pulse_r, stop_pulse_s;
    logic          reset_pulse_r, reset_pulse_s;
    logic          start_level_r;
    logic          control_r;
    logic [TW-1:0] idle_r, idle_s;
    logic [HW-1:0] hold_r, hold_s;
    logic [RW-1:0] rep_r, rep_s;
    logic          holding_r, holding_s;
    logic          set_mode_s;
    logic          timeout_s;

    assign set_mode_s = (mode_r == MODE_SET_TIME) || (mode_r == MODE_SET_ALARM);
    assign timeout_s  = set_mode_s && (idle_r == IDLE_MAX);

    // Next-state and next-output decode for the mode FSM and its sub-functions
    always_comb begin
        mode_s        = mode_r;
        sw_s          = sw_r;
        field_s       = field_r;
        inc_pulse_s   = 1'b0;
        stop_pulse_s  = 1'b0;
        reset_pulse_s = 1'b0;
        idle_s        = '0;
        hold_s        = hold_r;
        rep_s         = rep_r;
        holding_s     = holding_r;

        if (timeout_s) begin
            // The forced return to CLOCK swallows any press and increment in this cycle
            mode_s    = MODE_CLOCK;
            holding_s = 1'b0;
        end else if (press_r[B_MODE]) begin
            // A mode press discards all other presses in the same cycle
            case (mode_r)
                MODE_CLOCK:     mode_s = MODE_SET_TIME;
                MODE_SET_TIME:  mode_s = MODE_SET_ALARM;
                MODE_SET_ALARM: mode_s = MODE_STOPWATCH;
                MODE_STOPWATCH: mode_s = MODE_CLOCK;
                default:        mode_s = MODE_CLOCK;
            endcase
            field_s   = 1'b0;
            holding_s = 1'b0;
        end else begin
            case (mode_r)
                MODE_SET_TIME, MODE_SET_ALARM: begin
                    if (|press_r) begin
                        idle_s = '0;
                    end else if (idle_r == IDLE_MAX) begin
                        idle_s = idle_r;
                    end else begin
                        idle_s = idle_r + IDLE_ONE;
                    end

                    if (press_r[B_SET]) begin
                        field_s = ~field_r;
                    end else begin
                        field_s = field_r;
                    end

                    if (press_r[B_START]) begin
                        inc_pulse_s = 1'b1;
                        holding_s   = 1'b1;
                        hold_s      = '0;
                        rep_s       = '0;
                    end else if (holding_r) begin
                        if (!deb_r[B_START]) begin
                            holding_s = 1'b0;
                        end else if (hold_r == HOLD_LAST) begin
                            inc_pulse_s = 1'b1;
                            hold_s      = HOLD_MAX;
                            rep_s       = '0;
                        end else if (hold_r == HOLD_MAX) begin
                            if (rep_r == REP_LAST) begin
                                inc_pulse_s = 1'b1;
                                rep_s       = '0;
                            end else begin
                                rep_s = rep_r + REP_ONE;
                            end
                        end else begin
                            hold_s = hold_r + HOLD_ONE;
                        end
                    end else begin
                        holding_s = 1'b0;
                    end
                end
                MODE_STOPWATCH: begin
                    // Start outranks Reset when both arrive together
                    if (press_r[B_START]) begin
                        case (sw_r)
                            SW_READY:   sw_s = SW_RUNNING;
                            SW_RUNNING: begin
                                sw_s         = SW_STOPPED;
                                stop_pulse_s = 1'b1;
                            end
                            SW_STOPPED: sw_s = SW_STOPPED;
                            default:    sw_s = SW_READY;
                        endcase
                    end else if (press_r[B_RESET]) begin
                        if (sw_r == SW_STOPPED) begin
                            sw_s          = SW_READY;
                            reset_pulse_s = 1'b1;
                        end else begin
                            sw_s = sw_r;
                        end
                    end else begin
                        sw_s = sw_r;
                    end
                end
                default: begin
                    mode_s = mode_r;
                end
            endcase
        end
    end

    // State and output registers; the level outputs follow the next state
    always_ff @(posedge Clock_1MSec) begin
        if (Reset) begin
            mode_r        <= MODE_CLOCK;
            sw_r          <= SW_READY;
            field_r       <= 1'b0;
            inc_pulse_r   <= 1'b0;
            stop_pulse_r  <= 1'b0;
            reset_pulse_r <= 1'b0;
            start_level_r <= 1'b0;
            control_r     <= 1'b0;
            idle_r        <= '0;
            hold_r        <= '0;
            rep_r         <= '0;
            holding_r     <= 1'b0;
        end else begin
            mode_r        <= mode_s;
            sw_r          <= sw_s;
            field_r       <= field_s;
            inc_pulse_r   <= inc_pulse_s;
            stop_pulse_r  <= stop_pulse_s;
            reset_pulse_r <= reset_pulse_s;
            start_level_r <= (sw_s == SW_RUNNING);
            control_r     <= (mode_s == MODE_SET_TIME) || (mode_s == MODE_SET_ALARM);
            idle_r        <= idle_s;
            hold_r        <= hold_s;
            rep_r         <= rep_s;
            holding_r     <= holding_s;
        end
    end

    assign Mode      = mode_r;
    assign Set_Field = field_r;
    assign Inc_P     = inc_pulse_r;
    assign Start_S   = start_level_r;
    assign Stop_S    = stop_pulse_r;
    assign Reset_S   = reset_pulse_r;
    assign Control   = control_r;

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Self-checking bench for watch_mode_ctrl: directed scenarios with fixed expectations,
// then randomized button activity checked cycle by cycle against an event-level model.
module tb_watch_mode_ctrl;

    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 5;
    localparam int TMO  = 50;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       b_mode  = 1'b0;
    logic       b_start = 1'b0;
    logic       b_reset = 1'b0;
    logic       b_set   = 1'b0;
    logic [1:0] mode;
    logic       set_field, inc_p, start_s, stop_s, reset_s, control;
    logic [7:0] dut_vec;

    int checks = 0;
    int errors = 0;

    watch_mode_ctrl #(
        .DEBOUNCE_MS(DEB), .HOLD_MS(HOLD), .REPEAT_MS(REP), .TIMEOUT_MS(TMO)
    ) dut (
        .Clock_1MSec(clk), .Reset(rst),
        .Btn_Mode(b_mode), .Btn_Start(b_start), .Btn_Reset(b_reset), .Btn_Set(b_set),
        .Mode(mode), .Set_Field(set_field), .Inc_P(inc_p), .Start_S(start_s),
        .Stop_S(stop_s), .Reset_S(reset_s), .Control(control)
    );

    assign dut_vec = {mode, set_field, inc_p, start_s, stop_s, reset_s, control};

    always #5 clk = ~clk;

    // ---------------- reference model (event level) ----------------
    // Debounce: a level changes once the last DEB synchronised samples (raw delayed
    // two edges) all disagree with it. A press is acted on two edges after the
    // debounced rise. Hold and repeat timing is computed from the edge number of the
    // press. The idle timeout is computed from the edge number of the last activity.
    int         m_edge = 0;
    int         m_mode, m_sw, m_last_act, m_press_f;
    bit         m_field, m_inc, m_stop, m_rstp, m_holding;
    bit [31:0]  m_hist [4];
    bit [3:0]   m_deb;
    bit [3:0]   m_pipe [$];

    function automatic logic [7:0] model_vec();
        bit ctrl;
        ctrl = (m_mode == 1) || (m_mode == 2);
        return {m_mode[1:0], m_field, m_inc, (m_sw == 1), m_stop, m_rstp, ctrl};
    endfunction

    task automatic model_step();
        bit [3:0] raw, p, nd;
        bit       set_mode, all1, all0;
        int       k;
        raw = {b_set, b_reset, b_start, b_mode};
        m_edge++;
        if (rst) begin
            m_mode = 0; m_sw = 0; m_field = 0; m_inc = 0; m_stop = 0; m_rstp = 0;
            m_holding = 0; m_deb = 4'b0000; m_last_act = m_edge; m_press_f = m_edge;
            for (int b = 0; b < 4; b++) m_hist[b] = 32'd0;
            m_pipe = '{4'b0000, 4'b0000};
            return;
        end
        p = m_pipe.pop_front();
        m_inc = 0; m_stop = 0; m_rstp = 0;
        set_mode = (m_mode == 1) || (m_mode == 2);
        if (set_mode && (m_edge - m_last_act == TMO + 1)) begin
            m_mode = 0; m_holding = 0;
        end else if (p[0]) begin
            m_mode = (m_mode + 1) % 4;
            m_field = 0; m_holding = 0;
            m_last_act = m_edge;
        end else if (set_mode) begin
            if (p != 4'b0000) m_last_act = m_edge;
            if (p[3]) m_field = !m_field;
            if (p[1]) begin
                m_inc = 1; m_holding = 1; m_press_f = m_edge;
            end else if (m_holding) begin
                if (!m_deb[1]) begin
                    m_holding = 0;
                end else begin
                    k = m_edge - m_press_f;
                    if (k == HOLD || (k > HOLD && (k - HOLD) % REP == 0)) m_inc = 1;
                end
            end
        end else if (m_mode == 3) begin
            if (p[1]) begin
                if (m_sw == 0) m_sw = 1;
                else if (m_sw == 1) begin m_sw = 2; m_stop = 1; end
            end else if (p[2] && m_sw == 2) begin
                m_sw = 0; m_rstp = 1;
            end
        end
        for (int b = 0; b < 4; b++) begin
            m_hist[b] = {m_hist[b][30:0], raw[b]};
            all1 = 1; all0 = 1;
            for (int i = 2; i < DEB + 2; i++) begin
                if (m_hist[b][i]) all0 = 0; else all1 = 0;
            end
            nd[b] = m_deb[b];
            if (!m_deb[b] && all1) nd[b] = 1;
            if (m_deb[b] && all0) nd[b] = 0;
        end
        m_pipe.push_back(nd & ~m_deb);
        m_deb = nd;
    endtask

    // One clock: inputs already applied, model advanced at the edge, outputs sampled 1 later
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Press one button (0 mode, 1 start, 2 reset, 3 set) for hi cycles, then release for lo
    task automatic press(input int b, input int hi, input int lo);
        case (b)
            0: b_mode = 1'b1;
            1: b_start = 1'b1;
            2: b_reset = 1'b1;
            default: b_set = 1'b1;
        endcase
        repeat (hi) tick();
        b_mode = 1'b0; b_start = 1'b0; b_reset = 1'b0; b_set = 1'b0;
        repeat (lo) tick();
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (dut_vec !== 8'h00) begin
                errors++;
                $display("FAIL reset_idle: outputs=%h expected 00 (cycle %0d)", dut_vec, i);
            end
        end
    endtask

    task automatic test_mode_cycle();
        logic [1:0] exp;
        b_mode = 1'b1;
        repeat (3) tick();
        b_mode = 1'b0;
        repeat (10) tick();
        checks++;
        if (mode !== 2'd0) begin
            errors++;
            $display("FAIL short_glitch: Mode=%0d expected 0", mode);
        end
        for (int n = 1; n <= 4; n++) begin
            exp = 2'(n % 4);
            b_mode = 1'b1;
            for (int t = 1; t <= 10; t++) begin
                tick();
                if (t == 7) begin
                    checks++;
                    if (mode !== 2'(n - 1)) begin
                        errors++;
                        $display("FAIL mode_early: Mode=%0d expected %0d", mode, n - 1);
                    end
                end
                if (t == 8) begin
                    checks++;
                    if (mode !== exp || control !== (exp == 2'd1 || exp == 2'd2)) begin
                        errors++;
                        $display("FAIL mode_advance: Mode=%0d Control=%0d expected Mode=%0d", mode, control, exp);
                    end
                end
            end
            b_mode = 1'b0;
            repeat (10) tick();
        end
    endtask

    task automatic test_stopwatch();
        repeat (3) press(0, 10, 10);
        checks++;
        if (mode !== 2'd3) begin
            errors++;
            $display("FAIL sw_enter: Mode=%0d expected 3", mode);
        end
        b_start = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t == 7) begin
                checks++;
                if (start_s !== 1'b0) begin errors++; $display("FAIL sw_start_early: Start_S=%0d expected 0", start_s); end
            end
            if (t == 8) begin
                checks++;
                if (start_s !== 1'b1 || stop_s !== 1'b0) begin
                    errors++; $display("FAIL sw_start: Start_S=%0d Stop_S=%0d expected 1 0", start_s, stop_s);
                end
            end
        end
        b_start = 1'b0;
        repeat (10) tick();
        b_start = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t == 8) begin
                checks++;
                if (start_s !== 1'b0 || stop_s !== 1'b1) begin
                    errors++; $display("FAIL sw_stop: Start_S=%0d Stop_S=%0d expected 0 1", start_s, stop_s);
                end
            end
            if (t == 9) begin
                checks++;
                if (stop_s !== 1'b0) begin errors++; $display("FAIL sw_stop_pulse: Stop_S=%0d expected 0", stop_s); end
            end
        end
        b_start = 1'b0;
        repeat (10) tick();
        b_start = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            if (t == 11) b_start = 1'b0;
            tick();
            checks++;
            if ({start_s, stop_s, reset_s} !== 3'b000) begin
                errors++; $display("FAIL sw_start_in_stopped: SSR=%b expected 000", {start_s, stop_s, reset_s});
            end
        end
        b_reset = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t == 8) begin
                checks++;
                if (reset_s !== 1'b1) begin errors++; $display("FAIL sw_reset: Reset_S=%0d expected 1", reset_s); end
            end
            if (t == 9) begin
                checks++;
                if (reset_s !== 1'b0 || start_s !== 1'b0) begin
                    errors++; $display("FAIL sw_reset_pulse: Reset_S=%0d Start_S=%0d expected 0 0", reset_s, start_s);
                end
            end
        end
        b_reset = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_set_mode();
        bit exp_inc;
        press(0, 10, 10);
        press(0, 10, 10);
        checks++;
        if (mode !== 2'd1 || control !== 1'b1 || set_field !== 1'b0) begin
            errors++; $display("FAIL set_enter: Mode=%0d Control=%0d Set_Field=%0d expected 1 1 0", mode, control, set_field);
        end
        b_start = 1'b1;
        for (int t = 1; t <= 46; t++) begin
            if (t == 41) b_start = 1'b0;
            tick();
            exp_inc = (t == 8) || (t == 28) || (t == 33) || (t == 38) || (t == 43);
            checks++;
            if (inc_p !== exp_inc) begin
                errors++; $display("FAIL inc_repeat: Inc_P=%0d expected %0d at cycle %0d", inc_p, exp_inc, t);
            end
        end
        b_set = 1'b1;
        for (int t = 1; t <= 60; t++) begin
            if (t == 11) b_set = 1'b0;
            tick();
            if (t == 8) begin
                checks++;
                if (set_field !== 1'b1) begin errors++; $display("FAIL set_field: Set_Field=%0d expected 1", set_field); end
            end
            if (t == 58) begin
                checks++;
                if (mode !== 2'd1) begin errors++; $display("FAIL idle_early: Mode=%0d expected 1", mode); end
            end
            if (t == 59) begin
                checks++;
                if (mode !== 2'd0 || control !== 1'b0) begin
                    errors++; $display("FAIL idle_timeout: Mode=%0d Control=%0d expected 0 0", mode, control);
                end
            end
        end
    endtask

    task automatic test_priority();
        repeat (3) press(0, 10, 10);
        b_mode = 1'b1;
        b_start = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t == 8) begin
                checks++;
                if (mode !== 2'd0 || start_s !== 1'b0) begin
                    errors++; $display("FAIL mode_priority: Mode=%0d Start_S=%0d expected 0 0", mode, start_s);
                end
            end
        end
        b_mode = 1'b0;
        b_start = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset_midrun();
        repeat (3) press(0, 10, 10);
        press(1, 10, 10);
        checks++;
        if (start_s !== 1'b1 || mode !== 2'd3) begin
            errors++; $display("FAIL midrun_running: Start_S=%0d Mode=%0d expected 1 3", start_s, mode);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (dut_vec !== 8'h00) begin
            errors++; $display("FAIL midrun_reset: outputs=%h expected 00", dut_vec);
        end
        repeat (5) tick();
        repeat (3) press(0, 10, 10);
        press(1, 10, 10);
        checks++;
        if (start_s !== 1'b1) begin
            errors++; $display("FAIL midrun_ready: Start_S=%0d expected 1", start_s);
        end
    endtask

    // ---------------- randomized run against the model ----------------
    task automatic test_random();
        int cnt [4];
        int quiet = 0;
        int shown = 0;
        logic [7:0] exp;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        b_mode = 1'b0; b_start = 1'b0; b_reset = 1'b0; b_set = 1'b0;
        for (int b = 0; b < 4; b++) cnt[b] = $urandom_range(1, 40);
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 999) == 0);
            if (quiet == 0 && $urandom_range(0, 299) == 0) quiet = 80;
            if (quiet > 0) begin
                quiet--;
                b_mode = 1'b0; b_start = 1'b0; b_reset = 1'b0; b_set = 1'b0;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (cnt[b] == 0) begin
                        case (b)
                            0: begin b_mode = !b_mode;
                                cnt[0] = b_mode ? $urandom_range(1, 15) : $urandom_range(20, 150); end
                            1: begin b_start = !b_start;
                                cnt[1] = b_start ? $urandom_range(1, 60) : $urandom_range(1, 60); end
                            2: begin b_reset = !b_reset;
                                cnt[2] = b_reset ? $urandom_range(1, 30) : $urandom_range(1, 80); end
                            default: begin b_set = !b_set;
                                cnt[3] = b_set ? $urandom_range(1, 30) : $urandom_range(1, 60); end
                        endcase
                    end else begin
                        cnt[b]--;
                    end
                end
            end
            tick();
            exp = model_vec();
            checks++;
            if (dut_vec !== exp) begin
                errors++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_cycle_%0d: {Mode,Fld,Inc,Start,Stop,Rst,Ctl}=%b expected %b", c, dut_vec, exp);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mode_cycle();
        test_stopwatch();
        test_set_mode();
        test_priority();
        test_reset_midrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
